// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - IF/MEM arbiter for one single-ported memory; optional perf counters via PERF_CNT_EN
module unified_mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
`ifdef PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  perf_if_grants,
    output logic [CNT_W-1:0]  perf_dm_grants,
    output logic [CNT_W-1:0]  perf_conflicts
`endif
);

    localparam int WC_W = $clog2(MAX_WAIT + 1);
    localparam logic [WC_W-1:0] WAIT_MAX = WC_W'(MAX_WAIT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY_IF = 2'd1,
        S_BUSY_DM = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic              r_if_ack;
    logic              r_dm_ack;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_dm_rdata;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [WC_W-1:0]   r_wait_cnt;
    logic              w_if_elig;
    logic              w_dm_elig;
    logic              w_grant_if;
    logic              w_grant_dm;
    logic              w_done_if;
    logic              w_done_dm;

    // A requester is not eligible in its own ack cycle, so a held request is never granted twice
    assign w_if_elig = if_req & ~r_if_ack;
    assign w_dm_elig = dm_req & ~r_dm_ack;
    assign w_done_if = (r_state == S_BUSY_IF) & mem_ready;
    assign w_done_dm = (r_state == S_BUSY_DM) & mem_ready;

    // State register; async reset abandons any in-flight access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Arbitration and next state: data wins unless fetch has waited MAX_WAIT cycles
    always_comb begin
        w_next_state = r_state;
        w_grant_if   = 1'b0;
        w_grant_dm   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_if_elig && w_dm_elig) begin
                    if (r_wait_cnt >= WAIT_MAX) begin
                        w_grant_if = 1'b1;
                    end else begin
                        w_grant_dm = 1'b1;
                    end
                end else if (w_if_elig) begin
                    w_grant_if = 1'b1;
                end else if (w_dm_elig) begin
                    w_grant_dm = 1'b1;
                end
                if (w_grant_if) begin
                    w_next_state = S_BUSY_IF;
                end else if (w_grant_dm) begin
                    w_next_state = S_BUSY_DM;
                end
            end
            S_BUSY_IF: if (mem_ready) w_next_state = S_IDLE;
            S_BUSY_DM: if (mem_ready) w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    // Memory command latch on grant, read-data capture and one-cycle ack pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_ack    <= 1'b0;
            r_dm_ack    <= 1'b0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
        end else begin
            if (w_grant_if) begin
                r_mem_we    <= 1'b0;
                r_mem_addr  <= if_addr;
                r_mem_wdata <= '0;
            end else if (w_grant_dm) begin
                r_mem_we    <= dm_we;
                r_mem_addr  <= dm_addr;
                r_mem_wdata <= dm_wdata;
            end
            r_if_ack <= w_done_if;
            r_dm_ack <= w_done_dm;
            if (w_done_if) begin
                r_if_rdata <= mem_rdata;
            end
            if (w_done_dm && !r_mem_we) begin
                r_dm_rdata <= mem_rdata;
            end
        end
    end

    // Fetch starvation counter: counts denied fetch cycles, saturates, clears on fetch grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if (w_grant_if) begin
            r_wait_cnt <= '0;
        end else if (if_req && (r_state != S_BUSY_IF) && !r_if_ack && (r_wait_cnt < WAIT_MAX)) begin
            r_wait_cnt <= r_wait_cnt + WC_W'(1);
        end
    end

    assign if_ack    = r_if_ack;
    assign dm_ack    = r_dm_ack;
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;
    assign mem_req   = (r_state != S_IDLE);
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_stall  = if_req & ~r_if_ack;
    assign dm_stall  = dm_req & ~r_dm_ack;

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] r_perf_if;
    logic [CNT_W-1:0] r_perf_dm;
    logic [CNT_W-1:0] r_perf_cf;

    // Wrapping grant and conflict counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_if <= '0;
            r_perf_dm <= '0;
            r_perf_cf <= '0;
        end else begin
            if (w_grant_if) r_perf_if <= r_perf_if + CNT_W'(1);
            if (w_grant_dm) r_perf_dm <= r_perf_dm + CNT_W'(1);
            if ((r_state == S_IDLE) && w_if_elig && w_dm_elig) r_perf_cf <= r_perf_cf + CNT_W'(1);
        end
    end

    assign perf_if_grants = r_perf_if;
    assign perf_dm_grants = r_perf_dm;
    assign perf_conflicts = r_perf_cf;
`endif

endmodule
